// File: rtl/stg_pipe_reg.sv
// Pipeline stage register for PC/instruction with valid/ready handshake, flush,
// NOP bubbles, optional 2-entry skid buffer and a saturating stall counter.
module stg_pipe_reg #(
  parameter int                 ADDR_W    = 24,
  parameter int                 DATA_W    = 24,
  parameter int                 SKID      = 1,
  parameter logic [DATA_W-1:0]  NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_valid,
  output logic              ow_ready,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  input  logic              iw_flush,
  output logic              ow_valid,
  input  logic              iw_ready,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic [CNT_W-1:0]  ow_stall_cnt
);

  logic              m_valid_reg, m_valid_next;
  logic [ADDR_W-1:0] m_pc_reg, m_pc_next;
  logic [DATA_W-1:0] m_instr_reg, m_instr_next;
  logic              s_valid_reg, s_valid_next;
  logic [ADDR_W-1:0] s_pc_reg, s_pc_next;
  logic [DATA_W-1:0] s_instr_reg, s_instr_next;
  logic              ready_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic accept;
  logic drain;

  assign accept = iw_valid & ow_ready;
  assign drain  = m_valid_reg & iw_ready;

  // Without a skid register ready is combinational; ready_reg then only marks
  // "out of reset" so ready stays low while reset is held.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign ow_ready = ready_reg;
    end else begin : g_comb_ready
      assign ow_ready = ready_reg & (~m_valid_reg | iw_ready);
    end
  endgenerate

  always_comb begin
    m_valid_next = m_valid_reg;
    m_pc_next    = m_pc_reg;
    m_instr_next = m_instr_reg;
    s_valid_next = s_valid_reg;
    s_pc_next    = s_pc_reg;
    s_instr_next = s_instr_reg;
    if (iw_flush) begin
      // PC is deliberately left as-is so the bubble carries the last PC
      m_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else if (s_valid_reg) begin
      if (drain) begin
        m_valid_next = 1'b1;
        m_pc_next    = s_pc_reg;
        m_instr_next = s_instr_reg;
        s_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!m_valid_reg || drain) begin
        m_valid_next = 1'b1;
        m_pc_next    = iw_pc;
        m_instr_next = iw_instr;
      end else if (SKID != 0) begin
        s_valid_next = 1'b1;
        s_pc_next    = iw_pc;
        s_instr_next = iw_instr;
      end
    end else if (drain) begin
      m_valid_next = 1'b0;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      m_valid_reg <= 1'b0;
      m_pc_reg    <= '0;
      m_instr_reg <= NOP_INSTR;
      s_valid_reg <= 1'b0;
      s_pc_reg    <= '0;
      s_instr_reg <= NOP_INSTR;
      ready_reg   <= 1'b0;
    end else begin
      m_valid_reg <= m_valid_next;
      m_pc_reg    <= m_pc_next;
      m_instr_reg <= m_instr_next;
      s_valid_reg <= s_valid_next;
      s_pc_reg    <= s_pc_next;
      s_instr_reg <= s_instr_next;
      ready_reg   <= (SKID != 0) ? ~s_valid_next : 1'b1;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      cnt_reg <= '0;
    end else if (m_valid_reg && !iw_ready && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign ow_valid     = m_valid_reg;
  assign ow_pc        = m_pc_reg;
  assign ow_instr     = m_valid_reg ? m_instr_reg : NOP_INSTR;
  assign ow_stall_cnt = cnt_reg;

endmodule

// File: tb/tb_stg_pipe_reg.sv
// Directed bench: one skid-buffered instance (4-bit counter, non-zero NOP) and
// one single-register instance, driven separately, shared clock and reset.
module tb_stg_pipe_reg;

  localparam logic [23:0] NOP_A = 24'hA5A5A5;

  logic clk;
  logic rst_n;

  logic        a_valid, a_flush, a_ready, a_oready, a_ovalid;
  logic [23:0] a_pc, a_instr, a_opc, a_oinstr;
  logic [3:0]  a_cnt;

  logic        b_valid, b_flush, b_ready, b_oready, b_ovalid;
  logic [23:0] b_pc, b_instr, b_opc, b_oinstr;
  logic [15:0] b_cnt;

  int checks;
  int failures;

  stg_pipe_reg #(.SKID(1), .CNT_W(4), .NOP_INSTR(NOP_A)) u_skid (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_valid(a_valid), .ow_ready(a_oready),
    .iw_pc(a_pc), .iw_instr(a_instr), .iw_flush(a_flush), .ow_valid(a_ovalid),
    .iw_ready(a_ready), .ow_pc(a_opc), .ow_instr(a_oinstr), .ow_stall_cnt(a_cnt)
  );

  stg_pipe_reg #(.SKID(0)) u_noskid (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_valid(b_valid), .ow_ready(b_oready),
    .iw_pc(b_pc), .iw_instr(b_instr), .iw_flush(b_flush), .ow_valid(b_ovalid),
    .iw_ready(b_ready), .ow_pc(b_opc), .ow_instr(b_oinstr), .ow_stall_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] ins(input logic [23:0] pc);
    return 24'hC00000 | pc;
  endfunction

  task automatic a_feed(input logic [23:0] pc);
    a_valid = 1'b1;
    a_pc    = pc;
    a_instr = ins(pc);
  endtask

  task automatic b_feed(input logic [23:0] pc);
    b_valid = 1'b1;
    b_pc    = pc;
    b_instr = ins(pc);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a_valid = 0; a_flush = 0; a_ready = 1; a_pc = 0; a_instr = 0;
    b_valid = 0; b_flush = 0; b_ready = 1; b_pc = 0; b_instr = 0;

    // Reset state while reset is held
    #12;
    check_val("rst_a_valid", a_ovalid, 0);
    check_val("rst_a_pc", a_opc, 0);
    check_val("rst_a_instr", a_oinstr, NOP_A);
    check_val("rst_a_cnt", a_cnt, 0);
    check_val("rst_a_ready", a_oready, 0);
    check_val("rst_b_ready", b_oready, 0);
    check_val("rst_b_instr", b_oinstr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("post_rst_a_ready", a_oready, 1);
    check_val("post_rst_b_ready", b_oready, 1);

    // Stream on skid instance
    a_feed(24'h10); tick();
    check_val("stream_v0", a_ovalid, 1);
    check_val("stream_pc0", a_opc, 24'h10);
    check_val("stream_in0", a_oinstr, ins(24'h10));
    a_feed(24'h11); tick();
    check_val("stream_pc1", a_opc, 24'h11);
    check_val("stream_in1", a_oinstr, ins(24'h11));
    a_feed(24'h12); tick();
    check_val("stream_v2", a_ovalid, 1);
    check_val("stream_pc2", a_opc, 24'h12);
    a_valid = 0; tick();
    check_val("stream_end_v", a_ovalid, 0);
    check_val("stream_end_nop", a_oinstr, NOP_A);
    check_val("stream_end_pc", a_opc, 24'h12);
    check_val("stream_cnt", a_cnt, 0);

    // Backpressure with skid buffer
    a_ready = 0; a_feed(24'h20); tick();
    check_val("bpA_pc20", a_opc, 24'h20);
    check_val("bpA_rdy1", a_oready, 1);
    a_feed(24'h21); tick();
    check_val("bpA_rdy_drop", a_oready, 0);
    check_val("bpA_hold20", a_opc, 24'h20);
    a_feed(24'h22); tick();
    check_val("bpA_cnt2", a_cnt, 2);
    tick();
    check_val("bpA_cnt3", a_cnt, 3);
    check_val("bpA_still20", a_opc, 24'h20);
    a_ready = 1; tick();
    check_val("bpA_pc21", a_opc, 24'h21);
    check_val("bpA_rdy_back", a_oready, 1);
    tick();
    check_val("bpA_pc22", a_opc, 24'h22);
    check_val("bpA_in22", a_oinstr, ins(24'h22));
    a_valid = 0; tick();
    check_val("bpA_empty", a_ovalid, 0);
    check_val("bpA_cnt_final", a_cnt, 3);

    // Backpressure without skid buffer (combinational ready)
    b_ready = 0; b_feed(24'h20); #1;
    check_val("bpB_rdy_empty", b_oready, 1);
    tick();
    check_val("bpB_pc20", b_opc, 24'h20);
    b_feed(24'h21); #1;
    check_val("bpB_rdy_comb0", b_oready, 0);
    tick(); tick(); tick();
    check_val("bpB_hold20", b_opc, 24'h20);
    check_val("bpB_cnt3", b_cnt, 3);
    b_ready = 1; #1;
    check_val("bpB_rdy_comb1", b_oready, 1);
    tick();
    check_val("bpB_pc21", b_opc, 24'h21);
    b_feed(24'h22); tick();
    check_val("bpB_pc22", b_opc, 24'h22);
    b_valid = 0; tick();
    check_val("bpB_empty", b_ovalid, 0);
    check_val("bpB_nop", b_oinstr, 0);
    check_val("bpB_cnt_final", b_cnt, 3);

    // Flush with M and S full plus an incoming entry
    a_ready = 0; a_feed(24'h30); tick();
    a_feed(24'h31); tick();
    check_val("fl_full_rdy", a_oready, 0);
    a_flush = 1; a_feed(24'h32); tick();
    check_val("fl_v", a_ovalid, 0);
    check_val("fl_nop", a_oinstr, NOP_A);
    check_val("fl_rdy", a_oready, 1);
    check_val("fl_pc_hold", a_opc, 24'h30);
    a_flush = 0; a_valid = 0; a_ready = 1; tick();
    check_val("fl_no_ghost", a_ovalid, 0);
    a_feed(24'h40); tick();
    check_val("fl_after_pc", a_opc, 24'h40);
    a_flush = 1; a_feed(24'h41); tick();
    check_val("fl_drop_v", a_ovalid, 0);
    check_val("fl_drop_pc", a_opc, 24'h40);
    a_flush = 0; a_valid = 0; tick();
    check_val("fl_drop_v2", a_ovalid, 0);
    check_val("fl_cnt", a_cnt, 5);

    // Counter saturation (4-bit)
    a_ready = 0; a_feed(24'h50); tick();
    a_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    check_val("sat_reach", a_cnt, 15);
    for (int i = 0; i < 10; i++) tick();
    check_val("sat_hold", a_cnt, 15);
    check_val("sat_pc", a_opc, 24'h50);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_v", a_ovalid, 0);
    check_val("arst_pc", a_opc, 0);
    check_val("arst_cnt", a_cnt, 0);
    check_val("arst_rdy", a_oready, 0);
    check_val("arst_nop", a_oinstr, NOP_A);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("arst_rdy_back", a_oready, 1);
    check_val("arst_v_after", a_ovalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
